// File: rtl/led_pattern_driver.sv
// led_pattern_driver: single-pin LED drive with off / on / blink / PWM breathe.
// Optional build macro LED_PATTERN_GAMMA_EN selects square-law breathe brightness
// (duty_eff = upper PWM_BITS bits of duty*duty); the default build is linear.
module led_pattern_driver #(
    parameter int HALF_PERIOD = 25000000,
    parameter int PWM_BITS    = 8,
    parameter int STEP_CLKS   = 97656
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic [1:0] MODE,
    output logic       LED,
    output logic       CYCLE_DONE
);

    localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int SW = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;

    localparam logic [HW-1:0]       HALF_LAST = HW'(HALF_PERIOD - 1);
    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_CLKS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_ON    = 3'd1,
        S_BLINK = 3'd2,
        S_UP    = 3'd3,
        S_DOWN  = 3'd4
    } state_t;

    state_t              r_state;
    logic [1:0]          r_mode_q;
    logic [PWM_BITS-1:0] r_duty;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [HW-1:0]       r_half_cnt;
    logic [SW-1:0]       r_step_cnt;
    logic                r_phase;
    logic                r_led;
    logic                r_cycle_done;

    logic                w_mode_chg;
    logic                w_half_tc;
    logic                w_step_tc;
    logic [PWM_BITS-1:0] w_duty_nxt;
    logic [PWM_BITS-1:0] w_duty_eff;
    logic                w_led_nxt;

    assign w_mode_chg = (MODE != r_mode_q);
    assign w_half_tc  = (r_half_cnt == HALF_LAST);
    assign w_step_tc  = (r_step_cnt == STEP_LAST);

    // Next duty value; saturates at both ends so it can never wrap.
    always_comb begin
        w_duty_nxt = r_duty;
        if (w_mode_chg) begin
            w_duty_nxt = '0;
        end else if (ENABLE && w_step_tc) begin
            if (r_state == S_UP && r_duty != DUTY_MAX)
                w_duty_nxt = r_duty + DUTY_ONE;
            else if (r_state == S_DOWN && r_duty != '0)
                w_duty_nxt = r_duty - DUTY_ONE;
        end
    end

`ifdef LED_PATTERN_GAMMA_EN
    logic [2*PWM_BITS-1:0] w_duty_sq;
    logic [PWM_BITS-1:0]   r_duty_gamma;

    assign w_duty_sq = {{PWM_BITS{1'b0}}, w_duty_nxt} * {{PWM_BITS{1'b0}}, w_duty_nxt};

    // Square of the duty being written, registered alongside duty so the
    // compare sees duty and its gamma value from the same cycle.
    always_ff @(posedge CLK) begin
        if (RESET)
            r_duty_gamma <= '0;
        else
            r_duty_gamma <= w_duty_sq[2*PWM_BITS-1:PWM_BITS];
    end

    assign w_duty_eff = r_duty_gamma;
`else
    assign w_duty_eff = r_duty;
`endif

    // LED next value from the current state; ENABLE low forces dark.
    always_comb begin
        w_led_nxt = 1'b0;
        if (ENABLE) begin
            case (r_state)
                S_ON:          w_led_nxt = 1'b1;
                S_BLINK:       w_led_nxt = r_phase;
                S_UP, S_DOWN:  w_led_nxt = (r_pwm_cnt < w_duty_eff);
                default:       w_led_nxt = 1'b0;
            endcase
        end
    end

    // Pattern FSM, timers and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= S_OFF;
            r_mode_q     <= 2'b00;
            r_duty       <= '0;
            r_pwm_cnt    <= '0;
            r_half_cnt   <= '0;
            r_step_cnt   <= '0;
            r_phase      <= 1'b0;
            r_led        <= 1'b0;
            r_cycle_done <= 1'b0;
        end else begin
            r_pwm_cnt    <= r_pwm_cnt + DUTY_ONE;
            r_duty       <= w_duty_nxt;
            r_led        <= w_led_nxt;
            r_cycle_done <= 1'b0;
            if (w_mode_chg) begin
                // Mode entry wins over any timer event in the same cycle.
                r_mode_q   <= MODE;
                r_half_cnt <= '0;
                r_step_cnt <= '0;
                r_phase    <= 1'b1;
                case (MODE)
                    2'b00:   r_state <= S_OFF;
                    2'b01:   r_state <= S_ON;
                    2'b10:   r_state <= S_BLINK;
                    default: r_state <= S_UP;
                endcase
            end else if (ENABLE) begin
                case (r_state)
                    S_BLINK: begin
                        if (w_half_tc) begin
                            r_half_cnt <= '0;
                            r_phase    <= ~r_phase;
                        end else begin
                            r_half_cnt <= r_half_cnt + HW'(1);
                        end
                    end
                    S_UP: begin
                        if (w_step_tc) begin
                            r_step_cnt <= '0;
                            if (w_duty_nxt == DUTY_MAX)
                                r_state <= S_DOWN;
                        end else begin
                            r_step_cnt <= r_step_cnt + SW'(1);
                        end
                    end
                    S_DOWN: begin
                        if (w_step_tc) begin
                            r_step_cnt <= '0;
                            if (w_duty_nxt == '0) begin
                                r_state      <= S_UP;
                                r_cycle_done <= 1'b1;
                            end
                        end else begin
                            r_step_cnt <= r_step_cnt + SW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign LED        = r_led;
    assign CYCLE_DONE = r_cycle_done;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver with small timing parameters.
module tb_led_pattern_driver;

    localparam int HP = 4;
    localparam int PB = 3;
    localparam int SC = 2;
    localparam int NSTEPS = 2 * ((1 << PB) - 1);  // duty steps per full breathe cycle
    localparam int PERIOD = NSTEPS * SC;          // clocks per breathe cycle

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ENABLE;
    logic [1:0] MODE;
    logic       LED;
    logic       CYCLE_DONE;

    int checks = 0;
    int errors = 0;

    led_pattern_driver #(
        .HALF_PERIOD (HP),
        .PWM_BITS    (PB),
        .STEP_CLKS   (SC)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ENABLE     (ENABLE),
        .MODE       (MODE),
        .LED        (LED),
        .CYCLE_DONE (CYCLE_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Breathe duty t clocks after the mode-entry edge.
    function automatic int bduty(input int t);
        int s;
        s = (t / SC) % NSTEPS;
        return (s <= NSTEPS / 2) ? s : NSTEPS - s;
    endfunction

    function automatic int eff(input int d);
`ifdef LED_PATTERN_GAMMA_EN
        return (d * d) >> PB;
`else
        return d;
`endif
    endfunction

    // Two reset clocks with MODE preset; the next tick is edge 1.
    task automatic start(input logic [1:0] m);
        RESET = 1'b1; ENABLE = 1'b1; MODE = m;
        tick; tick;
        RESET = 1'b0;
    endtask

    task automatic test_reset;
        logic e;
        RESET = 1'b1; ENABLE = 1'b1; MODE = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (LED !== 1'b0 || CYCLE_DONE !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: LED=%b CD=%b want 0 0", i, LED, CYCLE_DONE);
            end
        end
        RESET = 1'b0;
        for (int m = 1; m <= 6; m++) begin
            tick;
            e = (m >= 2);
            checks++;
            if (LED !== e) begin
                errors++;
                $display("FAIL reset_on edge%0d: LED=%b want %b", m, LED, e);
            end
        end
    endtask

    task automatic test_blink;
        logic e;
        start(2'b10);
        for (int m = 1; m <= 20; m++) begin
            tick;
            e = (m >= 2) && (((m - 2) / HP) % 2 == 0);
            checks++;
            if (LED !== e) begin
                errors++;
                $display("FAIL blink edge%0d: LED=%b want %b", m, LED, e);
            end
        end
    endtask

    task automatic test_breathe;
        logic e, ecd;
        int   pulses = 0;
        start(2'b11);
        for (int m = 1; m <= 60; m++) begin
            tick;
            e   = (m >= 2) && (((m - 1) % (1 << PB)) < eff(bduty(m - 2)));
            ecd = (m > 1) && ((m - 1) % PERIOD == 0);
            if (CYCLE_DONE === 1'b1) pulses++;
            checks++;
            if (LED !== e || CYCLE_DONE !== ecd) begin
                errors++;
                $display("FAIL breathe edge%0d: LED=%b CD=%b want %b %b", m, LED, CYCLE_DONE, e, ecd);
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL breathe_pulses: got %0d want 2", pulses);
        end
    endtask

    task automatic test_enable;
        logic e;
        start(2'b10);
        tick; tick; tick;          // half_cnt is now 2, phase high
        ENABLE = 1'b0;
        for (int m = 4; m <= 13; m++) begin
            tick;
            checks++;
            if (LED !== 1'b0 || CYCLE_DONE !== 1'b0) begin
                errors++;
                $display("FAIL enable_low edge%0d: LED=%b CD=%b want 0 0", m, LED, CYCLE_DONE);
            end
        end
        ENABLE = 1'b1;
        for (int m = 14; m <= 21; m++) begin
            tick;
            e = (m <= 15) || (m >= 20);
            checks++;
            if (LED !== e) begin
                errors++;
                $display("FAIL enable_resume edge%0d: LED=%b want %b", m, LED, e);
            end
        end
    endtask

    task automatic test_mode_switch;
        logic e;
        start(2'b11);
        for (int m = 1; m <= 19; m++) tick;   // duty now 5, falling
        MODE = 2'b00;
        for (int n = 20; n <= 23; n++) begin
            tick;
            e = (n == 20) ? ((19 % (1 << PB)) < eff(5)) : 1'b0;
            checks++;
            if (LED !== e || CYCLE_DONE !== 1'b0) begin
                errors++;
                $display("FAIL switch_off edge%0d: LED=%b CD=%b want %b 0", n, LED, CYCLE_DONE, e);
            end
        end
        MODE = 2'b11;
        for (int n = 24; n <= 40; n++) begin
            tick;
            e = (n >= 25) && (((n - 1) % (1 << PB)) < eff(bduty(n - 1 - 24)));
            checks++;
            if (LED !== e || CYCLE_DONE !== 1'b0) begin
                errors++;
                $display("FAIL switch_restart edge%0d: LED=%b CD=%b want %b 0", n, LED, CYCLE_DONE, e);
            end
        end
    endtask

    initial begin
        RESET = 1'b1; ENABLE = 1'b1; MODE = 2'b00;
        test_reset;
        test_blink;
        test_breathe;
        test_enable;
        test_mode_switch;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
